// File: rtl/systolic_skew_feeder_if.sv
// Scratchpad read port, run control and skewed lane outputs of the systolic skew feeder.
interface systolic_skew_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 5
);
  logic                            start;
  logic [ADDR_WIDTH-1:0]           base_addr;
  logic                            mem_rd_en;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic [DATA_WIDTH*NUM_LANES-1:0] out_a;
  logic [DATA_WIDTH*NUM_LANES-1:0] out_b;
  logic [NUM_LANES-1:0]            out_valid;
  logic                            busy;
  logic                            done;

  modport master (
    output start, base_addr, mem_rdata,
    input  mem_rd_en, mem_addr, out_a, out_b, out_valid, busy, done
  );

  modport slave (
    input  start, base_addr, mem_rdata,
    output mem_rd_en, mem_addr, out_a, out_b, out_valid, busy, done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Bulk-loads A/B operand lanes from a synchronous scratchpad, then streams them into the PE
// array edges with a diagonal skew (lane k delayed by k cycles, idle slots zero).
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 4,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  systolic_skew_feeder_if.slave bus
);
  localparam int LD     = NUM_LANES * DEPTH;
  localparam int N      = 2 * LD;
  localparam int IW     = $clog2(N);
  localparam int QW     = (LD > 1) ? $clog2(LD) : 1;
  localparam int TW     = $clog2(DEPTH + NUM_LANES);
  localparam int T_LAST = DEPTH + NUM_LANES - 2;
  localparam int OW     = DATA_WIDTH * NUM_LANES;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            state;
  logic [IW-1:0]         rd_idx;
  logic                  rd_en_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  vld_p0;
  logic [IW-1:0]         idx_p0;
  logic [TW-1:0]         t;
  logic [DATA_WIDTH-1:0] qa [LD];
  logic [DATA_WIDTH-1:0] qb [LD];
  logic [OW-1:0]         out_a_r, out_b_r;
  logic [NUM_LANES-1:0]  out_v_r;
  logic                  busy_r, done_r;

  logic [TW-1:0]         slice_t;
  logic [OW-1:0]         nxt_a, nxt_b;
  logic [NUM_LANES-1:0]  nxt_v;

  function automatic logic [QW-1:0] qslot(input int lane, input int elem);
    return QW'(lane * DEPTH + elem);
  endfunction

  // Next diagonal slice: slice 0 is launched as the last word lands, later slices from t+1.
  always_comb begin
    slice_t = (state == S_STREAM) ? t + TW'(1) : '0;
    nxt_a   = '0;
    nxt_b   = '0;
    nxt_v   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      int d;
      d = int'(slice_t) - k;
      if (d >= 0 && d < DEPTH) begin
        nxt_a[k*DATA_WIDTH +: DATA_WIDTH] = qa[qslot(k, d)];
        nxt_b[k*DATA_WIDTH +: DATA_WIDTH] = qb[qslot(k, d)];
        nxt_v[k]                          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rd_idx  <= '0;
      rd_en_r <= 1'b0;
      addr_r  <= '0;
      vld_p0  <= 1'b0;
      idx_p0  <= '0;
      t       <= '0;
      out_a_r <= '0;
      out_b_r <= '0;
      out_v_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      for (int i = 0; i < LD; i++) begin
        qa[i] <= '0;
        qb[i] <= '0;
      end
    end else begin
      // p0: read issued last cycle; its data is on mem_rdata now and lands in its slot
      vld_p0 <= rd_en_r;
      idx_p0 <= rd_idx;
      if (vld_p0) begin
        if (idx_p0 < IW'(LD)) qa[QW'(idx_p0)]            <= bus.mem_rdata;
        else                  qb[QW'(int'(idx_p0) - LD)] <= bus.mem_rdata;
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_LOAD;
            rd_en_r <= 1'b1;
            addr_r  <= bus.base_addr;
            rd_idx  <= '0;
            busy_r  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (rd_en_r) begin
            if (rd_idx == IW'(N - 1)) begin
              rd_en_r <= 1'b0;
              addr_r  <= '0;
            end else begin
              rd_idx <= rd_idx + IW'(1);
              addr_r <= addr_r + ADDR_WIDTH'(1);
            end
          end
          if (vld_p0 && idx_p0 == IW'(N - 1)) begin
            state   <= S_STREAM;
            t       <= '0;
            out_a_r <= nxt_a;
            out_b_r <= nxt_b;
            out_v_r <= nxt_v;
          end
        end
        S_STREAM: begin
          if (t == TW'(T_LAST)) begin
            state   <= S_DONE;
            out_a_r <= '0;
            out_b_r <= '0;
            out_v_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            t       <= t + TW'(1);
            out_a_r <= nxt_a;
            out_b_r <= nxt_b;
            out_v_r <= nxt_v;
          end
        end
        default: begin
          state  <= S_IDLE;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rd_en = rd_en_r;
  assign bus.mem_addr  = addr_r;
  assign bus.out_a     = out_a_r;
  assign bus.out_b     = out_b_r;
  assign bus.out_valid = out_v_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: expectations from a plain-arithmetic reference model.
module tb_systolic_skew_feeder;
  localparam int DW    = 32;
  localparam int NL    = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int LD    = NL * DEPTH;
  localparam int N     = 2 * LD;
  localparam int MS    = 1 << AW;
  localparam int OW    = DW * NL;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ADDR_WIDTH(AW)) bus ();

  systolic_skew_feeder #(.DATA_WIDTH(DW), .NUM_LANES(NL), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [DW-1:0] mem [MS];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

  typedef struct {
    int            cyc;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic [NL-1:0] v;
  } slice_s;
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } addr_s;

  slice_s sb_q[$];
  addr_s  addr_q[$];
  int     done_q[$];
  int     runs[$];
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input bit ok, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: run starting at edge e0 reads N words from base, streams diagonal slices after
  // edges e0+N+1 .. e0+N+NL+DEPTH-1, and pulses done after the following edge.
  task automatic push_run(input int e0, input logic [AW-1:0] base);
    addr_s  ae;
    slice_s s;
    for (int i = 0; i < N; i++) begin
      ae.cyc  = e0 + i;
      ae.addr = AW'(int'(base) + i);
      addr_q.push_back(ae);
    end
    for (int ts = 0; ts <= NL + DEPTH - 2; ts++) begin
      s.cyc = e0 + N + 1 + ts;
      s.a   = '0;
      s.b   = '0;
      s.v   = '0;
      for (int k = 0; k < NL; k++) begin
        int d;
        d = ts - k;
        if (d >= 0 && d < DEPTH) begin
          s.a[k*DW +: DW] = mem[AW'(int'(base) + k * DEPTH + d)];
          s.b[k*DW +: DW] = mem[AW'(int'(base) + LD + k * DEPTH + d)];
          s.v[k]          = 1'b1;
        end
      end
      sb_q.push_back(s);
    end
    done_q.push_back(e0 + N + NL + DEPTH);
    runs.push_back(e0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic launch(input logic [AW-1:0] b, output int e0);
    bus.base_addr = b;
    bus.start     = 1'b1;
    e0            = cyc + 1;
    push_run(e0, b);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.base_addr = AW'($urandom);
  endtask

  task automatic fill_count();
    for (int i = 0; i < MS; i++) mem[i] = DW'(i + 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < MS; i++) mem[i] = $urandom;
  endtask

  // Monitor
  always @(negedge clk) begin
    bit     exp_busy;
    slice_s s;
    addr_s  ae;
    int     dc;
    exp_busy = 1'b0;
    foreach (runs[i]) if (cyc >= runs[i] && cyc <= runs[i] + N + NL + DEPTH - 1) exp_busy = 1'b1;
    check("busy", bus.busy == exp_busy, OW'(bus.busy), OW'(exp_busy));
    if (bus.out_valid != '0) begin
      check("slice_expected", sb_q.size() != 0, OW'(bus.out_valid), '0);
      if (sb_q.size() != 0) begin
        s = sb_q.pop_front();
        check("slice_cycle", cyc == s.cyc, OW'(cyc), OW'(s.cyc));
        check("slice_valid", bus.out_valid == s.v, OW'(bus.out_valid), OW'(s.v));
        check("slice_a", bus.out_a == s.a, bus.out_a, s.a);
        check("slice_b", bus.out_b == s.b, bus.out_b, s.b);
      end
    end else begin
      check("idle_lanes_zero", bus.out_a == '0 && bus.out_b == '0, bus.out_a | bus.out_b, '0);
    end
    if (bus.done) begin
      check("done_expected", done_q.size() != 0, OW'(cyc), '0);
      if (done_q.size() != 0) begin
        dc = done_q.pop_front();
        check("done_cycle", cyc == dc, OW'(cyc), OW'(dc));
      end
    end
    if (bus.mem_rd_en) begin
      check("read_expected", addr_q.size() != 0, OW'(bus.mem_addr), '0);
      if (addr_q.size() != 0) begin
        ae = addr_q.pop_front();
        check("read_cycle", cyc == ae.cyc, OW'(cyc), OW'(ae.cyc));
        check("read_addr", bus.mem_addr == ae.addr, OW'(bus.mem_addr), OW'(ae.addr));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    logic [AW-1:0] b;
    reset         = 1'b1;
    bus.start     = 1'b1;
    bus.base_addr = '0;
    fill_count();
    repeat (3) @(negedge clk);
    check("rst_out_a", bus.out_a == '0, bus.out_a, '0);
    check("rst_out_b", bus.out_b == '0, bus.out_b, '0);
    check("rst_out_valid", bus.out_valid == '0, OW'(bus.out_valid), '0);
    check("rst_busy", bus.busy == 1'b0, OW'(bus.busy), '0);
    check("rst_done", bus.done == 1'b0, OW'(bus.done), '0);
    check("rst_mem_rd_en", bus.mem_rd_en == 1'b0, OW'(bus.mem_rd_en), '0);
    bus.start = 1'b0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);

    // Counting pattern, base 0, with literal spot checks
    launch('0, e0);
    wait_until(e0 + 33);
    check("t2_a0_first", bus.out_a[31:0] == 32'd1, OW'(bus.out_a[31:0]), OW'(1));
    check("t2_b0_first", bus.out_b[31:0] == 32'd17, OW'(bus.out_b[31:0]), OW'(17));
    wait_until(e0 + 36);
    check("t2_a0_last", bus.out_a[31:0] == 32'd4, OW'(bus.out_a[31:0]), OW'(4));
    check("t2_a3_first", bus.out_a[127:96] == 32'd13, OW'(bus.out_a[127:96]), OW'(13));
    check("t2_b3_first", bus.out_b[127:96] == 32'd29, OW'(bus.out_b[127:96]), OW'(29));
    wait_until(e0 + 39);
    check("t2_a3_last", bus.out_a[127:96] == 32'd16, OW'(bus.out_a[127:96]), OW'(16));
    check("t2_b3_last", bus.out_b[127:96] == 32'd32, OW'(bus.out_b[127:96]), OW'(32));
    check("t2_done_early", bus.done == 1'b0, OW'(bus.done), '0);
    wait_until(e0 + 40);
    check("t2_done", bus.done == 1'b1, OW'(bus.done), OW'(1));
    wait_until(e0 + 43);

    // start re-pulsed in LOAD, STREAM and DONE
    launch('0, e0);
    wait_until(e0 + 5);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(e0 + 35);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(e0 + 40);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(e0 + 44);

    // Reset mid-STREAM, then a clean rerun
    fill_random();
    launch(AW'($urandom), e0);
    wait_until(e0 + 35);
    #2 reset = 1'b1;
    runs.delete();
    sb_q.delete();
    done_q.delete();
    addr_q.delete();
    #1;
    check("midrst_out_valid", bus.out_valid == '0, OW'(bus.out_valid), '0);
    check("midrst_out_a", bus.out_a == '0, bus.out_a, '0);
    check("midrst_busy", bus.busy == 1'b0, OW'(bus.busy), '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    fill_count();
    launch('0, e0);
    wait_until(e0 + 43);

    // Address wrap from base 16
    fill_random();
    launch(AW'(16), e0);
    wait_until(e0 + 43);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      launch(AW'($urandom_range(0, MS - 1)), e0);
      wait_until(e0 + 43);
    end

    // start held high across two back-to-back runs
    fill_random();
    b             = AW'($urandom);
    bus.base_addr = b;
    bus.start     = 1'b1;
    e0            = cyc + 1;
    push_run(e0, b);
    push_run(e0 + 42, b);
    wait_until(e0 + 60);
    bus.start = 1'b0;
    wait_until(e0 + 88);

    check("left_slices", sb_q.size() == 0, OW'(sb_q.size()), '0);
    check("left_done", done_q.size() == 0, OW'(done_q.size()), '0);
    check("left_reads", addr_q.size() == 0, OW'(addr_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
